fetch_exec_controller: RTL and testbench

Synchronous control sequencer for the 3-stage (fetch / decode / execute) processor. It generates the stage timing strobes that qualify the instruction decoder, and it drives the datapath load, increment and ALU-select enables. It also sequences input/output instructions through a valid/ack handshake with a bounded wait. It sits between the instruction register, the program counter / memory address logic, the accumulator/ALU and the I/O ports.

---
 rtl/fetch_exec_controller.sv | 156 +++++++++++++++
 tb/tb_fetch_exec_controller.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fetch_exec_controller.sv
// Fetch/decode/execute control sequencer with bounded I/O handshake wait.
// Optional feature macro: SINGLE_STEP_EN (adds step input and PAUSE state).
module fetch_exec_controller #(
   parameter int IO_TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] ir,
   input  logic       in_valid,
   input  logic       out_ready,
`ifdef SINGLE_STEP_EN
   input  logic       step,
`endif
   output logic       t_fetch,
   output logic       t_decode,
   output logic       t_exec,
   output logic       mar_load,
   output logic       mem_rd,
   output logic       ir_load,
   output logic       pc_inc,
   output logic       acc_load,
   output logic [2:0] alu_op,
   output logic       in_ack,
   output logic       out_valid,
   output logic       halted,
   output logic       io_err
);

   localparam logic [3:0] OP_LOAD = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_INP  = 4'b0101;
   localparam logic [3:0] OP_OUTP = 4'b0110;
   localparam logic [3:0] OP_HALT = 4'b1111;
   localparam logic [7:0] LAST    = 8'(IO_TIMEOUT - 1);

`ifdef SINGLE_STEP_EN
   typedef enum logic [2:0] {FETCH1, FETCH2, DECODE, EXEC, IO_WAIT, HALT, PAUSE} state_t;
   localparam state_t RESUME = PAUSE;
`else
   typedef enum logic [2:0] {FETCH1, FETCH2, DECODE, EXEC, IO_WAIT, HALT} state_t;
   localparam state_t RESUME = FETCH1;
`endif

   state_t     state;
   logic [3:0] op_q;
   logic [7:0] cnt;
   logic       xfer;
   logic       unused_operand;

   // Operand index goes straight to the register file, not through here.
   assign unused_operand = ^ir[3:0];
   assign xfer = (op_q == OP_INP) ? in_valid : out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= FETCH1;
         op_q   <= 4'b0000;
         cnt    <= 8'd0;
         halted <= 1'b0;
         io_err <= 1'b0;
      end else begin
         case (state)
            FETCH1: state <= FETCH2;
            FETCH2: state <= DECODE;
            DECODE: begin
               op_q <= ir[7:4];
               if (ir[7:4] == OP_HALT) begin
                  state  <= HALT;
                  halted <= 1'b1;
               end else begin
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (op_q == OP_INP || op_q == OP_OUTP) begin
                  cnt   <= 8'd0;
                  state <= IO_WAIT;
               end else begin
                  state <= RESUME;
               end
            end
            IO_WAIT: begin
               // A transfer on the last allowed cycle still counts as success.
               if (xfer) begin
                  state <= RESUME;
               end else if (cnt == LAST) begin
                  io_err <= 1'b1;
                  state  <= RESUME;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            HALT: state <= HALT;
`ifdef SINGLE_STEP_EN
            PAUSE: if (step) state <= FETCH1;
`endif
            default: state <= FETCH1;
         endcase
      end
   end

   always_comb begin
      t_fetch   = 1'b0;
      t_decode  = 1'b0;
      t_exec    = 1'b0;
      mar_load  = 1'b0;
      mem_rd    = 1'b0;
      ir_load   = 1'b0;
      pc_inc    = 1'b0;
      acc_load  = 1'b0;
      alu_op    = 3'b000;
      in_ack    = 1'b0;
      out_valid = 1'b0;
      if (!rst) begin
         case (state)
            FETCH1: begin
               t_fetch  = 1'b1;
               mar_load = 1'b1;
            end
            FETCH2: begin
               t_fetch = 1'b1;
               mem_rd  = 1'b1;
               ir_load = 1'b1;
               pc_inc  = 1'b1;
            end
            DECODE: t_decode = 1'b1;
            EXEC: begin
               t_exec = 1'b1;
               case (op_q)
                  OP_LOAD: begin acc_load = 1'b1; alu_op = 3'b000; end
                  OP_ADD:  begin acc_load = 1'b1; alu_op = 3'b001; end
                  OP_SUB:  begin acc_load = 1'b1; alu_op = 3'b010; end
                  OP_AND:  begin acc_load = 1'b1; alu_op = 3'b011; end
                  default: ;
               endcase
            end
            IO_WAIT: begin
               t_exec = 1'b1;
               if (op_q == OP_INP) begin
                  if (in_valid) begin
                     in_ack   = 1'b1;
                     acc_load = 1'b1;
                     alu_op   = 3'b100;
                  end
               end else begin
                  out_valid = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_exec_controller.sv
// Directed bench for fetch_exec_controller (IO_TIMEOUT=4); step path under SINGLE_STEP_EN.
module tb_fetch_exec_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ir;
   logic       in_valid;
   logic       out_ready;
   logic       step;
   logic       t_fetch, t_decode, t_exec, mar_load, mem_rd, ir_load, pc_inc;
   logic       acc_load, in_ack, out_valid, halted, io_err;
   logic [2:0] alu_op;
   logic [14:0] obs;

   int vectors = 0;
   int miscompares = 0;
   logic err_e = 1'b0;

   // Packed view: {t_fetch,t_decode,t_exec,mar_load,mem_rd,ir_load,pc_inc,acc_load,alu_op,in_ack,out_valid,halted,io_err}
   localparam logic [14:0] B_TF  = 15'h4000;
   localparam logic [14:0] B_TD  = 15'h2000;
   localparam logic [14:0] B_TE  = 15'h1000;
   localparam logic [14:0] B_MAR = 15'h0800;
   localparam logic [14:0] B_RD  = 15'h0400;
   localparam logic [14:0] B_IRL = 15'h0200;
   localparam logic [14:0] B_PCI = 15'h0100;
   localparam logic [14:0] B_ACC = 15'h0080;
   localparam logic [14:0] B_ACK = 15'h0008;
   localparam logic [14:0] B_OV  = 15'h0004;
   localparam logic [14:0] B_HLT = 15'h0002;
   localparam logic [14:0] V_F1  = B_TF | B_MAR;
   localparam logic [14:0] V_F2  = B_TF | B_RD | B_IRL | B_PCI;

   always #5 clk = ~clk;

   fetch_exec_controller #(.IO_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .ir(ir), .in_valid(in_valid), .out_ready(out_ready),
`ifdef SINGLE_STEP_EN
      .step(step),
`endif
      .t_fetch(t_fetch), .t_decode(t_decode), .t_exec(t_exec), .mar_load(mar_load),
      .mem_rd(mem_rd), .ir_load(ir_load), .pc_inc(pc_inc), .acc_load(acc_load),
      .alu_op(alu_op), .in_ack(in_ack), .out_valid(out_valid), .halted(halted),
      .io_err(io_err)
   );

   assign obs = {t_fetch, t_decode, t_exec, mar_load, mem_rd, ir_load, pc_inc,
                 acc_load, alu_op, in_ack, out_valid, halted, io_err};

   function automatic logic [14:0] alu(input logic [2:0] op);
      return 15'(op) << 4;
   endfunction

   task automatic chk(input string tag, input logic [14:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Leaves the bench one cycle past EXEC/IO_WAIT, with the DUT back in FETCH1.
   task automatic finish_instr();
      cyc(); #1;
`ifdef SINGLE_STEP_EN
      chk("pause", 15'(err_e));
      cyc(); #1;
`endif
   endtask

   task automatic run_alu(input string tag, input logic [7:0] iv, input logic [14:0] exec_v);
      ir = iv;
      chk({tag, "_f1"}, V_F1 | 15'(err_e));
      cyc(); #1; chk({tag, "_f2"}, V_F2 | 15'(err_e));
      cyc(); #1; chk({tag, "_dec"}, B_TD | 15'(err_e));
      cyc(); #1; chk({tag, "_exec"}, exec_v | 15'(err_e));
      finish_instr();
   endtask

   task automatic io_front(input string tag, input logic [7:0] iv);
      ir = iv;
      chk({tag, "_f1"}, V_F1 | 15'(err_e));
      cyc(); #1; chk({tag, "_f2"}, V_F2 | 15'(err_e));
      cyc(); #1; chk({tag, "_dec"}, B_TD | 15'(err_e));
      cyc(); #1; chk({tag, "_exec"}, B_TE | 15'(err_e));
   endtask

   initial begin
      rst = 1'b1; step = 1'b1;
      ir = 8'($urandom); in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
      cyc(); #1; chk("rst_a", 15'h0);
      ir = 8'($urandom); in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
      cyc(); #1; chk("rst_b", 15'h0);
      cyc(); rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;

      run_alu("add",  8'h23, B_TE | B_ACC | alu(3'b001));
      run_alu("sub",  8'h38, B_TE | B_ACC | alu(3'b010));
      run_alu("and",  8'h41, B_TE | B_ACC | alu(3'b011));
      run_alu("load", 8'h15, B_TE | B_ACC | alu(3'b000));
      run_alu("nop",  8'h70, B_TE);

      // INP, producer arrives on the third wait cycle
      io_front("inp", 8'h50);
      cyc(); #1; chk("inp_w1", B_TE);
      cyc(); #1; chk("inp_w2", B_TE);
      cyc(); in_valid = 1'b1; #1; chk("inp_w3", B_TE | B_ACK | B_ACC | alu(3'b100));
      finish_instr();
      in_valid = 1'b0;

      // OUTP with no consumer: four cycles of out_valid, then sticky error
      io_front("outto", 8'h60);
      for (int i = 0; i < 4; i++) begin
         cyc(); #1; chk("outto_wait", B_TE | B_OV);
      end
      err_e = 1'b1;
      finish_instr();

      // OUTP aborted by reset mid-wait
      io_front("outrst", 8'h60);
      cyc(); #1; chk("outrst_w1", B_TE | B_OV | 15'(err_e));
      cyc(); rst = 1'b1; out_ready = 1'b1;
      err_e = 1'b0;
      cyc(); #1; chk("outrst_held", 15'h0);
      cyc(); rst = 1'b0; out_ready = 1'b0; #1;

      // OUTP where the consumer accepts on the last allowed cycle
      io_front("outok", 8'h60);
      for (int i = 0; i < 3; i++) begin
         cyc(); #1; chk("outok_wait", B_TE | B_OV);
      end
      cyc(); out_ready = 1'b1; #1; chk("outok_last", B_TE | B_OV);
      finish_instr();
      out_ready = 1'b0;

`ifdef SINGLE_STEP_EN
      step = 1'b0;
      run_alu("ss_load", 8'h12, B_TE | B_ACC | alu(3'b000));
      chk("ss_pause0", 15'h0);
      for (int i = 0; i < 9; i++) begin
         cyc(); #1; chk("ss_pause", 15'h0);
      end
      cyc(); step = 1'b1; #1; chk("ss_step", 15'h0);
      cyc(); #1;
`endif

      // HALT holds regardless of further ir changes
      ir = 8'hF0;
      chk("halt_f1", V_F1);
      cyc(); #1; chk("halt_f2", V_F2);
      cyc(); #1; chk("halt_dec", B_TD);
      for (int i = 0; i < 5; i++) begin
         cyc(); ir = 8'($urandom); in_valid = 1'($urandom_range(0, 1)); #1;
         chk("halt_hold", B_HLT);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
